seq_pattern_detector: RTL

//  Programmable N-element sequence detector on a valid-qualified input stream.

---
 rtl/seq_pattern_detector.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
//   Programmable SEQ_LEN-element sequence detector on a valid-qualified stream.
//   The pattern is held in registers (reset value DEFAULT_PAT, element 0 in the
//   LSBs) and can be rewritten one element at a time through the cfg port.
//   Matching is non-overlapping: after a full match the search restarts from
//   element 0. On a mismatch the only retained overlap is "the offending
//   element equals pattern element 0".
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   in_valid      in_data is consumed this cycle
//   in_data       stream element (DATA_W)
//   cfg_we        write pattern element cfg_idx with cfg_data; clears progress
//   cfg_idx       element index; indices >= SEQ_LEN are ignored
//   cfg_data      element value (DATA_W)
//   clear         clear sticky flag and match counter
//   match         one-cycle pulse, cycle after the final element is accepted
//   match_sticky  set on match, held until clear/reset
//   match_count   saturating match counter (CNT_W)
//   progress      elements matched so far (0..SEQ_LEN-1)
//
// Build option
//   SEQ_DET_TIMEOUT_EN : when defined, TIMEOUT_CYC consecutive idle cycles
//   (in_valid=0) during a partial match drop the progress back to 0.
// -----------------------------------------------------------------------------
module seq_pattern_detector #(
   parameter int unsigned                DATA_W      = 8,
   parameter int unsigned                SEQ_LEN     = 3,
   parameter int unsigned                CNT_W       = 8,
   parameter logic [SEQ_LEN*DATA_W-1:0]  DEFAULT_PAT = {8'h3C, 8'hB2, 8'h1F},
   parameter int unsigned                TIMEOUT_CYC = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic [DATA_W-1:0]              in_data,
   input  logic                           cfg_we,
   input  logic [$clog2(SEQ_LEN)-1:0]     cfg_idx,
   input  logic [DATA_W-1:0]              cfg_data,
   input  logic                           clear,
   output logic                           match,
   output logic                           match_sticky,
   output logic [CNT_W-1:0]               match_count,
   output logic [$clog2(SEQ_LEN+1)-1:0]   progress
);

   localparam int unsigned IDX_W = $clog2(SEQ_LEN);
   localparam int unsigned PRG_W = $clog2(SEQ_LEN + 1);
   localparam logic [PRG_W-1:0] PRG_LAST = PRG_W'(SEQ_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // Coarse phase of the search; the exact position lives in prog_q.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,   // nothing matched yet
      S_TRACK = 2'd1,   // partial match, more than one element still needed
      S_LAST  = 2'd2    // waiting for the final pattern element
   } state_e;

   state_e                          state_q, state_d;
   logic [PRG_W-1:0]                prog_q, prog_d;
   logic [SEQ_LEN-1:0][DATA_W-1:0]  pat_q, pat_d;
   logic                            match_q, match_d;
   logic                            sticky_q, sticky_d;
   logic [CNT_W-1:0]                count_q, count_d;

   logic [DATA_W-1:0]               cur_elem;
   logic                            elem_hit;
   logic                            first_hit;
   logic                            cfg_ok;
   logic                            idle_expire;

   // Element compares: expected element at the current position, and element 0
   // for the restart-on-mismatch case. Full-width compare, no masking.
   always_comb begin
      cur_elem  = pat_q[IDX_W'(prog_q)];
      elem_hit  = (in_data == cur_elem);
      first_hit = (in_data == pat_q[0]);
      cfg_ok    = (32'(cfg_idx) < SEQ_LEN);
   end

`ifdef SEQ_DET_TIMEOUT_EN
   localparam int unsigned       TO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] idle_q, idle_d;

   // Idle counter: runs only on idle cycles during a partial match; anything
   // else (valid input, cfg write, no progress) returns it to zero.
   always_comb begin
      idle_d      = '0;
      idle_expire = 1'b0;
      if (!cfg_we && !in_valid && (state_q != S_IDLE)) begin
         if (idle_q == TO_LAST) begin
            idle_expire = 1'b1;
         end else begin
            idle_d = idle_q + TO_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   logic unused_timeout;

   assign idle_expire    = 1'b0;
   assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

   // Next-state, pattern update and match bookkeeping.
   always_comb begin
      state_d  = state_q;
      prog_d   = prog_q;
      pat_d    = pat_q;
      match_d  = 1'b0;
      sticky_d = sticky_q;
      count_d  = count_q;

      if (cfg_we) begin
         // Pattern change invalidates any partial match; a concurrent input
         // element is dropped.
         prog_d = '0;
         if (cfg_ok) begin
            pat_d[cfg_idx] = cfg_data;
         end
      end else if (in_valid) begin
         if (elem_hit) begin
            if (state_q == S_LAST) begin
               prog_d  = '0;
               match_d = 1'b1;
            end else begin
               prog_d = prog_q + PRG_W'(1);
            end
         end else begin
            prog_d = first_hit ? PRG_W'(1) : '0;
         end
      end else if (idle_expire) begin
         prog_d = '0;
      end

      if (prog_d == '0) begin
         state_d = S_IDLE;
      end else if (prog_d == PRG_LAST) begin
         state_d = S_LAST;
      end else begin
         state_d = S_TRACK;
      end

      // A match in the same cycle as clear wins: sticky set, count restarts at 1.
      if (match_d) begin
         sticky_d = 1'b1;
         if (clear) begin
            count_d = CNT_W'(1);
         end else if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
         end
      end else if (clear) begin
         sticky_d = 1'b0;
         count_d  = '0;
      end
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         prog_q   <= '0;
         pat_q    <= DEFAULT_PAT;
         match_q  <= 1'b0;
         sticky_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         prog_q   <= prog_d;
         pat_q    <= pat_d;
         match_q  <= match_d;
         sticky_q <= sticky_d;
         count_q  <= count_d;
      end
   end

   assign match        = match_q;
   assign match_sticky = sticky_q;
   assign match_count  = count_q;
   assign progress     = prog_q;

endmodule
